// File: rtl/data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_arbiter
//  Purpose  : Shares one single-port data memory (synchronous write,
//             registered read) between the CPU datapath (port A) and the
//             debug/UART unit (port B). Round-robin arbitration, req/ack
//             handshake, one access in flight, fixed three-state sequence
//             IDLE -> ACCESS -> RESP.
//  Ports    :
//    clk, reset           clock (rising edge), async active-high reset
//    a_req/a_write/a_addr/a_wdata   port A request, held until a_ack
//    a_ack/a_rdata        port A one-cycle completion pulse / read data
//    b_*                  same as port A, for port B
//    mem_write/mem_addr/mem_in_data  drive the data memory
//    mem_out_data         registered read data from the data memory
//    busy                 high whenever the arbiter is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module data_memory_arbiter #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,

  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,

  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in_data,
  input  logic [DATA_W-1:0] mem_out_data,

  output logic              busy
);

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;  // port that won the most recent grant
  logic   sel;         // port owning the access in flight

  // Round-robin decision: B wins only when A is absent, or when both ask
  // and A was the last one served.
  logic grant_any;
  logic grant_b;

  always_comb begin
    grant_any = a_req | b_req;
    grant_b   = b_req & (~a_req | (last_grant == PORT_A));
  end

  // Read data is broadcast to both ports; only the acked port may use it.
  assign a_rdata = mem_out_data;
  assign b_rdata = mem_out_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      last_grant  <= PORT_B;
      sel         <= PORT_A;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_in_data <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          if (grant_any) begin
            // Latch the winner's request so later input changes cannot
            // disturb the access in flight.
            if (grant_b) begin
              mem_write   <= b_write;
              mem_addr    <= b_addr;
              mem_in_data <= b_wdata;
              sel         <= PORT_B;
              last_grant  <= PORT_B;
            end else begin
              mem_write   <= a_write;
              mem_addr    <= a_addr;
              mem_in_data <= a_wdata;
              sel         <= PORT_A;
              last_grant  <= PORT_A;
            end
            busy  <= 1'b1;
            state <= ACCESS;
          end
        end

        ACCESS: begin
          // The memory acts on this edge; write enable must not linger.
          mem_write <= 1'b0;
          a_ack     <= (sel == PORT_A);
          b_ack     <= (sel == PORT_B);
          state     <= RESP;
        end

        RESP: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          a_ack     <= 1'b0;
          b_ack     <= 1'b0;
          mem_write <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_memory_arbiter
//  Purpose  : Directed self-checking bench for data_memory_arbiter, with a
//             behavioural single-port data memory attached.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_arbiter;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              a_req = 1'b0, a_write = 1'b0;
  logic [ADDR_W-1:0] a_addr = '0;
  logic [DATA_W-1:0] a_wdata = '0;
  logic              a_ack;
  logic [DATA_W-1:0] a_rdata;
  logic              b_req = 1'b0, b_write = 1'b0;
  logic [ADDR_W-1:0] b_addr = '0;
  logic [DATA_W-1:0] b_wdata = '0;
  logic              b_ack;
  logic [DATA_W-1:0] b_rdata;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_in_data;
  logic [DATA_W-1:0] mem_out_data;
  logic              busy;

  int compared   = 0;
  int mismatched = 0;

  data_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_write(mem_write), .mem_addr(mem_addr), .mem_in_data(mem_in_data),
    .mem_out_data(mem_out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // Behavioural data memory: synchronous write, registered (read-old) read.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = '0;
    mem_out_data = '0;
  end
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_in_data;
    mem_out_data <= mem[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_req = 1'b0;
    b_req = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // One complete uncontended access with exact cycle-by-cycle checks.
  // exp_rd/alt_rd: acceptable read values (equal unless the outcome is open).
  task automatic access(input bit port_b, input bit wr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] exp_rd,
                        input logic [DATA_W-1:0] alt_rd, input string tag);
    logic [DATA_W-1:0] rd;
    if (!port_b) begin
      a_req = 1'b1; a_write = wr; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_write = wr; b_addr = addr; b_wdata = wd;
    end
    step();  // granting edge -> ACCESS
    check({tag, " busy_access"}, busy, 1);
    check({tag, " mem_write_access"}, mem_write, wr);
    check({tag, " mem_addr_access"}, mem_addr, addr);
    if (wr) check({tag, " mem_in_data_access"}, mem_in_data, wd);
    check({tag, " acks_access"}, {a_ack, b_ack}, 0);
    // Disturb the held inputs; the latched request must be unaffected.
    if (!port_b) begin a_addr = ~addr; a_wdata = ~wd; a_write = ~wr; end
    else         begin b_addr = ~addr; b_wdata = ~wd; b_write = ~wr; end
    step();  // -> RESP
    check({tag, " a_ack_resp"}, a_ack, !port_b);
    check({tag, " b_ack_resp"}, b_ack, port_b);
    check({tag, " mem_write_resp"}, mem_write, 0);
    check({tag, " mem_addr_held"}, mem_addr, addr);
    if (!wr) begin
      rd = port_b ? b_rdata : a_rdata;
      check({tag, " rdata"}, ((rd === exp_rd) || (rd === alt_rd)), 1);
    end
    a_req = 1'b0;
    b_req = 1'b0;
    step();  // -> IDLE
    check({tag, " busy_idle"}, busy, 0);
    check({tag, " acks_idle"}, {a_ack, b_ack}, 0);
  endtask

  initial begin
    int na, nb, nw;
    bit expect_b;

    // ---- Asynchronous reset before any clock edge ----
    #2 reset = 1'b1;
    #1;
    check("rst a_ack", a_ack, 0);
    check("rst b_ack", b_ack, 0);
    check("rst mem_write", mem_write, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_in_data", mem_in_data, 0);
    check("rst busy", busy, 0);
    step();
    step();
    reset = 1'b0;

    // ---- Idle with no requests ----
    for (int i = 0; i < 10; i++) begin
      step();
      check("idle mem_write", mem_write, 0);
      check("idle busy", busy, 0);
    end

    // ---- Port A write then read ----
    access(1'b0, 1'b1, 11'h000, 16'h0001, 16'h0000, 16'h0000, "A_wr0");
    access(1'b0, 1'b0, 11'h000, 16'h0000, 16'h0001, 16'h0001, "A_rd0");

    // ---- Port B write then read ----
    access(1'b1, 1'b1, 11'h020, 16'h0014, 16'h0000, 16'h0000, "B_wr20");
    access(1'b1, 1'b0, 11'h020, 16'h0000, 16'h0014, 16'h0014, "B_rd20");

    // ---- Contention right after reset: A first, then B ----
    do_reset();
    a_req = 1'b1; a_write = 1'b1; a_addr = 11'h001; a_wdata = 16'h000F;
    b_req = 1'b1; b_write = 1'b0; b_addr = 11'h001; b_wdata = 16'hDEAD;
    step();
    check("cont A mem_write", mem_write, 1);
    check("cont A mem_in_data", mem_in_data, 16'h000F);
    step();
    check("cont A a_ack", a_ack, 1);
    check("cont A b_ack", b_ack, 0);
    a_req = 1'b0;
    step();
    check("cont gap acks", {a_ack, b_ack}, 0);
    step();
    check("cont B busy", busy, 1);
    check("cont B mem_write", mem_write, 0);
    check("cont B mem_addr", mem_addr, 11'h001);
    step();
    check("cont B b_ack", b_ack, 1);
    check("cont B a_ack", a_ack, 0);
    check("cont B rdata", b_rdata, 16'h000F);
    b_req = 1'b0;
    step();
    check("cont end acks", {a_ack, b_ack}, 0);

    // ---- Fairness: both requesting continuously ----
    do_reset();
    a_req = 1'b1; a_write = 1'b1; a_addr = 11'h007; a_wdata = 16'h1234;
    b_req = 1'b1; b_write = 1'b0; b_addr = 11'h007; b_wdata = 16'h0000;
    na = 0; nb = 0; nw = 0; expect_b = 1'b0;
    for (int cyc = 0; cyc < 60 && (na + nb) < 12; cyc++) begin
      step();
      if (mem_write) begin
        nw++;
        check("fair write only in access", {busy, a_ack, b_ack}, 3'b100);
      end
      if (a_ack || b_ack) begin
        check("fair order a_ack", a_ack, !expect_b);
        check("fair order b_ack", b_ack, expect_b);
        if (b_ack) begin
          check("fair b_rdata", b_rdata, 16'h1234);
          nb++;
        end else begin
          na++;
        end
        expect_b = ~expect_b;
      end
    end
    a_req = 1'b0;
    b_req = 1'b0;
    check("fair A acks", na, 6);
    check("fair B acks", nb, 6);
    check("fair write cycles", nw, 6);
    step(); step(); step();

    // ---- Reset during ACCESS of an A write ----
    a_req = 1'b1; a_write = 1'b1; a_addr = 11'h005; a_wdata = 16'hBEEF;
    step();
    check("abort mem_write before", mem_write, 1);
    #2 reset = 1'b1;
    a_req = 1'b0;
    #1;
    check("abort mem_write", mem_write, 0);
    check("abort busy", busy, 0);
    check("abort mem_addr", mem_addr, 0);
    check("abort acks", {a_ack, b_ack}, 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      check("abort no a_ack", a_ack, 0);
    end
    access(1'b0, 1'b0, 11'h005, 16'h0000, 16'h0000, 16'hBEEF, "A_rd5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
